uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync.sv | 28 ++
 rtl/uart_rx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions.
// Used by the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS      = 8;
    localparam int OVERSAMPLE_DEF = 16;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_START = 2'd1;
    localparam state_t S_DATA  = 2'd2;
    localparam state_t S_STOP  = 2'd3;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input.
// Reset value is parameterised so idle-high lines reset high.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    // Two-stage resync of the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, oversampled, with valid/ready output.
// Bit centres are found by counting sample_tick strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 ref_clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_IX = IW'(DATA_BITS - 1);

    logic                 w_rx;
    logic                 w_half;
    logic                 w_full;
    logic                 w_load;
    logic                 w_take;

    state_t               r_state;
    logic                 r_armed;
    logic [CW-1:0]        r_tick;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_ovr;

    uart_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (ref_clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx)
    );

    assign w_half = (r_tick == HALF_M1);
    assign w_full = (r_tick == FULL_M1);
    assign w_load = sample_tick && (r_state == S_STOP) && w_full;
    assign w_take = r_valid && ready;

    // Frame FSM: start detect, centre alignment, data shift, stop sample
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
            r_tick  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else if (sample_tick) begin
            case (r_state)
                S_IDLE: begin
                    r_tick <= '0;
                    if (w_rx) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        // Disarm until the line is seen high again,
                        // so a held-low break starts only one frame.
                        r_armed <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_half) begin
                        r_tick <= '0;
                        r_idx  <= '0;
                        r_state <= w_rx ? S_IDLE : S_DATA;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_full) begin
                        r_tick         <= '0;
                        r_shift[r_idx] <= w_rx;
                        r_idx          <= r_idx + 1'b1;
                        if (r_idx == LAST_IX) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_STOP: begin
                    // Leave at the stop centre to resync half a bit early
                    if (w_full) begin
                        r_tick  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tick  <= '0;
                end
            endcase
        end
    end

    // Output holding register with handshake and overrun tracking
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_load) begin
            r_data  <= r_shift;
            r_ferr  <= !w_rx;
            r_valid <= 1'b1;
            if (r_valid && !ready) begin
                r_ovr <= 1'b1;
            end else if (w_take) begin
                r_ovr <= 1'b0;
            end
        end else if (w_take) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule
